alu_selftest: RTL
=================

ALU_SELFTEST -- requirements
Module: alu_selftest

Interface
REQ-001 SHALL have parameter NUM_VEC, default 16: number of test vectors in the vector table (1..32).
REQ-002 SHALL have parameter STOP_ON_FAIL, default 0: when 1, the run ends at the first mismatch.
REQ-003 SHALL have these ports: clk input 1, the single clock, all logic on its rising edge.
REQ-004 SHALL have reset input 1, synchronous, active-low.
REQ-005 SHALL have start input 1, a one-cycle pulse that begins a run.
REQ-006 SHALL have A and B, each output 32, the operands driven to the ALU.
REQ-007 SHALL have ALUFun output 6 (ALU opcode) and Sign output 1 (signed-compare/overflow select).
REQ-008 SHALL have Z input 32 (ALU result) and Zero, V, N inputs 1 each (ALU flags).
REQ-009 SHALL have busy output 1: a run is in progress.
REQ-010 SHALL have done output 1: a one-cycle pulse at the end of a run.
REQ-011 SHALL have pass output 1: the last run had zero mismatches; valid from done until the next start.
REQ-012 SHALL have fail_count output 6 (mismatches in the last run) and fail_index output 5 (index of the first failing vector).

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, CHECK, FINISH.
REQ-014 SHALL go IDLE->DRIVE on start=1: vec_idx=0, fail_count=0, pass cleared, fail_index=0.
REQ-015 SHALL, in DRIVE, register A/B/ALUFun/Sign from table[vec_idx], so operands are stable for the whole CHECK cycle, then go to CHECK.
REQ-016 SHALL, in CHECK, sample the combinational ALU outputs and compare Z, Zero, N, and V under the per-vector mask from REQ-017.
REQ-017 SHALL give each vector a chk_V mask bit: V is compared only for ADD (000000) and SUB (000001); Zero and N are always compared.
REQ-018 SHALL, on a mismatch, increment fail_count, saturating at 63, and load fail_index on the first mismatch only.
REQ-019 SHALL, from CHECK, go to FINISH if vec_idx==NUM_VEC-1 or (STOP_ON_FAIL and mismatch); otherwise vec_idx++ and go to DRIVE.
REQ-020 SHALL, in FINISH, assert done for exactly 1 cycle, set pass=(fail_count==0 including the current check), and return to IDLE.
REQ-021 SHALL have run latency from start to done of 2*NUM_VEC+1 cycles with no stop; busy=1 in DRIVE/CHECK/FINISH.
REQ-022 SHALL ignore start while busy.
REQ-023 SHALL hold A, B, ALUFun, Sign and all result outputs in IDLE.
REQ-024 SHALL use ALU encodings: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, PASSA 011010, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, GTZ 111111.
REQ-025 SHALL use shift vectors that carry the shamt in A[4:0] and the shifted operand in B.
REQ-026 SHALL expect compare results Z={31'b0,cond}.

Reset
REQ-027 SHALL, with reset=0 at a clock edge, force state=IDLE, vec_idx=0, A=B=0, ALUFun=000000, Sign=0, busy=0, done=0, pass=0, fail_count=0, fail_index=0.
REQ-028 SHALL abort a run when reset occurs mid-run, with no done pulse; the first start after release begins a fresh run.

Structure
REQ-029 SHALL put the ALUFun opcode constants, the vector record type {A,B,ALUFun,Sign,expZ,expZero,expV,expN,chk_V} and the default vector table in shared package alu_pkg, also used by the ALU.
REQ-030 SHALL place the vector table in sub-module alu_vec_rom: combinational read, index in, record out.

Verification
REQ-031 SHALL test with a correct ALU attached: start pulse -> busy 1 for 33 cycles, done at cycle 33, pass=1, fail_count=0.
REQ-032 SHALL test a vector ADD A=7FFFFFFF, B=70000000, Sign=1 -> sampled expZ=EFFFFFFF, V=1, N=1; with the V line stuck at 0 -> fail_count=1, fail_index equals that vector's index, pass=0.
REQ-033 SHALL test STOP_ON_FAIL=1 with the Z bit 0 stuck-at-1 and vector 0 = AND 5,99 (expZ=1) still passing, vector 3 = SUB 80000001,F (expZ=7FFFFFF2) failing -> done 8 cycles after start, fail_index=3.
REQ-034 SHALL test a second start during a run -> ignored, with run length unchanged.
REQ-035 SHALL test reset asserted in vector 5's CHECK -> next cycle busy=0, outputs zero, no done; a new start completes normally.
REQ-036 SHALL test SRA A=2, B=FFFFFFF9 -> expZ=FFFFFFFE, and LT Sign=1 A=FFFFFFF9, B=0000000A -> Z=1 compared correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, the self-test vector record and the
// default vector table. The ALU under test and the self-test engine both use it.
package alu_pkg;

  localparam logic [5:0] ALU_ADD   = 6'b000000;
  localparam logic [5:0] ALU_SUB   = 6'b000001;
  localparam logic [5:0] ALU_AND   = 6'b011000;
  localparam logic [5:0] ALU_OR    = 6'b011110;
  localparam logic [5:0] ALU_XOR   = 6'b010110;
  localparam logic [5:0] ALU_NOR   = 6'b010001;
  localparam logic [5:0] ALU_PASSA = 6'b011010;
  localparam logic [5:0] ALU_SLL   = 6'b100000;
  localparam logic [5:0] ALU_SRL   = 6'b100001;
  localparam logic [5:0] ALU_SRA   = 6'b100011;
  localparam logic [5:0] ALU_EQ    = 6'b110011;
  localparam logic [5:0] ALU_NEQ   = 6'b110001;
  localparam logic [5:0] ALU_LT    = 6'b110101;
  localparam logic [5:0] ALU_LEZ   = 6'b111101;
  localparam logic [5:0] ALU_GTZ   = 6'b111111;

  localparam logic [5:0] FAIL_MAX = 6'd63;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  alufun;
    logic        sign;
    logic [31:0] exp_z;
    logic        exp_zero;
    logic        exp_v;
    logic        exp_n;
    logic        chk_v;
  } alu_vec_t;

  localparam int DEFAULT_VECS = 16;

  // Shifts carry shamt in a[4:0] and the shifted operand in b; compares yield {31'b0, cond}.
  // Vectors 0..2 all have exp_z[0]=1 so a bit-0 stuck-at-1 first shows up at vector 3.
  localparam alu_vec_t VEC_TABLE [DEFAULT_VECS] = '{
    '{32'h0000_0005, 32'h0000_0099, ALU_AND,   1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'h0000_F0F0, 32'h0000_000F, ALU_OR,    1'b0, 32'h0000_F0FF, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'hFFFF_0000, 32'h0F0F_0F0F, ALU_XOR,   1'b0, 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b1, 1'b0},
    '{32'h8000_0001, 32'h0000_000F, ALU_SUB,   1'b0, 32'h7FFF_FFF2, 1'b0, 1'b0, 1'b0, 1'b1},
    '{32'h7FFF_FFFF, 32'h7000_0000, ALU_ADD,   1'b1, 32'hEFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b1},
    '{32'h0F0F_0F0F, 32'hF0F0_F0F0, ALU_NOR,   1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'h1234_5678, 32'hDEAD_BEEF, ALU_PASSA, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'h0000_0004, 32'h0000_0001, ALU_SLL,   1'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'h0000_0008, 32'h8000_0000, ALU_SRL,   1'b0, 32'h0080_0000, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'h0000_0002, 32'hFFFF_FFF9, ALU_SRA,   1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0},
    '{32'h0000_0055, 32'h0000_0055, ALU_EQ,    1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'h0000_0055, 32'h0000_0055, ALU_NEQ,   1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'hFFFF_FFF9, 32'h0000_000A, ALU_LT,    1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'h0000_0000, 32'h0000_0000, ALU_LEZ,   1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'h8000_0000, 32'h0000_0000, ALU_GTZ,   1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'hFFFF_FFFF, 32'h0000_0001, ALU_ADD,   1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1}
  };

endpackage

// File: rtl/alu_selftest_rom.sv
// Combinational vector table lookup; indices past the default table wrap around it.
module alu_vec_rom
  import alu_pkg::*;
(
  input  logic [4:0] idx,
  output alu_vec_t   vec
);

  assign vec = VEC_TABLE[4'(idx % 5'(DEFAULT_VECS))];

endmodule

// File: rtl/alu_selftest.sv
// ALU built-in self-test engine: drives each table vector to the ALU, checks the
// combinational result one cycle later and reports pass / fail count / first failure.
module alu_selftest
  import alu_pkg::*;
#(
  parameter int NUM_VEC      = 16,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [5:0]  ALUFun,
  output logic        Sign,
  input  logic [31:0] Z,
  input  logic        Zero,
  input  logic        V,
  input  logic        N,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  fail_count,
  output logic [4:0]  fail_index
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_FINISH} state_t;

  state_t     state;
  logic [4:0] vec_idx;
  alu_vec_t   vec;
  logic       mismatch;
  logic       last_vec;

  alu_vec_rom u_rom (
    .idx (vec_idx),
    .vec (vec)
  );

  // vec_idx is stable from DRIVE through CHECK, so vec still describes the driven operands.
  always_comb begin
    mismatch = (Z != vec.exp_z) || (Zero != vec.exp_zero) || (N != vec.exp_n) ||
               (vec.chk_v && (V != vec.exp_v));
    last_vec = (vec_idx == 5'(NUM_VEC - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      vec_idx    <= '0;
      A          <= '0;
      B          <= '0;
      ALUFun     <= ALU_ADD;
      Sign       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      fail_index <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge fail_count/vec_idx regardless of statement order.
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_DRIVE;
            vec_idx    <= '0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            fail_count <= '0;
            fail_index <= '0;
          end
        end
        S_DRIVE: begin
          A      <= vec.a;
          B      <= vec.b;
          ALUFun <= vec.alufun;
          Sign   <= vec.sign;
          state  <= S_CHECK;
        end
        S_CHECK: begin
          if (mismatch) begin
            if (fail_count != FAIL_MAX) fail_count <= fail_count + 6'd1;
            if (fail_count == '0)       fail_index <= vec_idx;
          end
          if (last_vec || (STOP_ON_FAIL && mismatch)) begin
            state <= S_FINISH;
          end else begin
            vec_idx <= vec_idx + 5'd1;
            state   <= S_DRIVE;
          end
        end
        S_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (fail_count == '0);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
